// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF stage sequencer: stage codes, FSM states,
// command header layout and the command size in words.
package ekf_pkg;

    localparam logic [2:0] STAGE_IDLE  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b011;
    localparam logic [2:0] STAGE_ASSOC = 3'b100;

    localparam int HDR_CODE_LSB = 0;
    localparam int HDR_CODE_MSB = 2;
    localparam int HDR_LAST_BIT = 31;
    localparam int CMD_WORDS    = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_H,
        ST_RD_A,
        ST_RD_B,
        ST_CAP_B,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_RDY,
        ST_DONE
    } seq_state_e;

    // Codes 000 and anything above ASSOC are rejected as malformed commands.
    function automatic logic stage_code_valid(input logic [2:0] code);
        return (code != STAGE_IDLE) && (code <= STAGE_ASSOC);
    endfunction

endpackage

// File: rtl/ekf_stage_seq_if.sv
// Command-memory read port: the sequencer is master, the memory is slave.
// Read data is expected exactly one cycle after cmd_en.
interface ekf_stage_seq_if #(
    parameter int CMD_AW = 10
);
    logic              cmd_en;
    logic [CMD_AW-1:0] cmd_addr;
    logic [31:0]       cmd_dout;

    modport master (output cmd_en, output cmd_addr, input cmd_dout);
    modport slave  (input cmd_en, input cmd_addr, output cmd_dout);
endinterface

// File: rtl/ekf_stage_seq.sv
// Fetches 3-word commands from command memory and issues EKF stage requests.
// Optional watchdog on the wait states is enabled by defining SEQ_TIMEOUT_EN.
module ekf_stage_seq
    import ekf_pkg::*;
#(
    parameter int RSA_DW = 32,
    parameter int CMD_AW = 10,
    parameter int TMO_W  = 16
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [CMD_AW-1:0]    base_addr,
    ekf_stage_seq_if.master      cmd_bus,
    output logic [2:0]           stage_val,
    output logic [RSA_DW-1:0]    vlr,
    output logic [RSA_DW-1:0]    alpha,
    output logic [RSA_DW-1:0]    rk,
    output logic [RSA_DW-1:0]    phi,
    input  logic                 stage_rdy,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    seq_state_e          state_q, state_d;
    logic [CMD_AW-1:0]   p_q, p_d;
    logic [CMD_AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic                cmd_en_q, cmd_en_d;
    logic [2:0]          hdr_code_q, hdr_code_d;
    logic                hdr_last_q, hdr_last_d;
    logic [31:0]         word_a_q, word_a_d;
    logic                issue_cnt_q, issue_cnt_d;
    logic [2:0]          stage_val_q, stage_val_d;
    logic [RSA_DW-1:0]   vlr_q, vlr_d, alpha_q, alpha_d;
    logic [RSA_DW-1:0]   rk_q, rk_d, phi_q, phi_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    // Command words are signed fixed-point; sign-extend to the operand width.
    function automatic logic [RSA_DW-1:0] to_operand(input logic [31:0] w);
        return RSA_DW'($signed(w));
    endfunction

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        hdr_code_d  = hdr_code_q;
        hdr_last_d  = hdr_last_q;
        word_a_d    = word_a_q;
        issue_cnt_d = issue_cnt_q;
        vlr_d       = vlr_q;
        alpha_d     = alpha_q;
        rk_d        = rk_q;
        phi_d       = phi_q;
        err_d       = err_q;
`ifdef SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d     = base_addr;
                    err_d   = 1'b0;
                    state_d = ST_RD_H;
                end
            end
            ST_RD_H: state_d = ST_RD_A;
            ST_RD_A: begin
                hdr_code_d = cmd_bus.cmd_dout[HDR_CODE_MSB:HDR_CODE_LSB];
                hdr_last_d = cmd_bus.cmd_dout[HDR_LAST_BIT];
                state_d    = ST_RD_B;
            end
            ST_RD_B: begin
                word_a_d = cmd_bus.cmd_dout;
                state_d  = ST_CAP_B;
            end
            ST_CAP_B: begin
                if (!stage_code_valid(hdr_code_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (hdr_code_q == STAGE_PRD) begin
                        vlr_d   = to_operand(word_a_q);
                        alpha_d = to_operand(cmd_bus.cmd_dout);
                    end else begin
                        rk_d  = to_operand(word_a_q);
                        phi_d = to_operand(cmd_bus.cmd_dout);
                    end
                    issue_cnt_d = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!issue_cnt_q) begin
                    issue_cnt_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_ACK;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                if (!stage_rdy) begin
                    state_d = ST_WAIT_RDY;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == '1) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_WAIT_RDY: begin
                if (stage_rdy) begin
                    if (hdr_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        p_d     = p_q + CMD_AW'(CMD_WORDS);
                        state_d = ST_RD_H;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == '1) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        cmd_en_d   = 1'b0;
        cmd_addr_d = cmd_addr_q;
        case (state_d)
            ST_RD_H: begin
                cmd_en_d   = 1'b1;
                cmd_addr_d = p_d;
            end
            ST_RD_A: begin
                cmd_en_d   = 1'b1;
                cmd_addr_d = p_d + CMD_AW'(1);
            end
            ST_RD_B: begin
                cmd_en_d   = 1'b1;
                cmd_addr_d = p_d + CMD_AW'(2);
            end
            default: ;
        endcase
        stage_val_d = (state_d == ST_ISSUE) ? hdr_code_d : STAGE_IDLE;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            cmd_addr_q  <= '0;
            cmd_en_q    <= 1'b0;
            hdr_code_q  <= '0;
            hdr_last_q  <= 1'b0;
            word_a_q    <= '0;
            issue_cnt_q <= 1'b0;
            stage_val_q <= STAGE_IDLE;
            vlr_q       <= '0;
            alpha_q     <= '0;
            rk_q        <= '0;
            phi_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_en_q    <= cmd_en_d;
            hdr_code_q  <= hdr_code_d;
            hdr_last_q  <= hdr_last_d;
            word_a_q    <= word_a_d;
            issue_cnt_q <= issue_cnt_d;
            stage_val_q <= stage_val_d;
            vlr_q       <= vlr_d;
            alpha_q     <= alpha_d;
            rk_q        <= rk_d;
            phi_q       <= phi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign cmd_bus.cmd_en   = cmd_en_q;
    assign cmd_bus.cmd_addr = cmd_addr_q;
    assign stage_val        = stage_val_q;
    assign vlr              = vlr_q;
    assign alpha            = alpha_q;
    assign rk               = rk_q;
    assign phi              = phi_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Randomized bench for ekf_stage_seq: a command-memory model, a stage_rdy
// responder and a command-level reference model of the expected run.
module tb_ekf_stage_seq;
    import ekf_pkg::*;

    localparam int CMD_AW   = 10;
    localparam int MEM_SIZE = 1 << CMD_AW;
    localparam int BUDGET   = 3000;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              start;
    logic [CMD_AW-1:0] base_addr;
    logic [2:0]        stage_val;
    logic [31:0]       vlr, alpha, rk, phi;
    logic              stage_rdy;
    logic              busy, done, err;

    ekf_stage_seq_if #(.CMD_AW(CMD_AW)) cmd_bus ();

    ekf_stage_seq #(.RSA_DW(32), .CMD_AW(CMD_AW), .TMO_W(16)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .base_addr (base_addr),
        .cmd_bus   (cmd_bus),
        .stage_val (stage_val),
        .vlr       (vlr),
        .alpha     (alpha),
        .rk        (rk),
        .phi       (phi),
        .stage_rdy (stage_rdy),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MEM_SIZE];

    always @(posedge clk) begin
        if (cmd_bus.cmd_en) cmd_bus.cmd_dout <= mem[cmd_bus.cmd_addr];
    end

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference operand registers and the command list for the next run.
    logic [31:0] m_vlr, m_alpha, m_rk, m_phi;
    logic [2:0]  c_code [8];
    logic [31:0] c_a [8];
    logic [31:0] c_b [8];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_stage_val"}, stage_val, 0);
        checkOutput({pfx, "_cmd_en"}, cmd_bus.cmd_en, 0);
        checkOutput({pfx, "_cmd_addr"}, cmd_bus.cmd_addr, 0);
        checkOutput({pfx, "_vlr"}, vlr, 0);
        checkOutput({pfx, "_alpha"}, alpha, 0);
        checkOutput({pfx, "_rk"}, rk, 0);
        checkOutput({pfx, "_phi"}, phi, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_err"}, err, 0);
    endtask

    // Runs one sequence of ncmd commands from base and checks it end to end.
    task automatic applyStimulus(input int base, input int ncmd, input int drop_cfg,
                                 input int hold_cfg, input bit poke_start);
        int          exp_reads[$];
        int          obs_reads[$];
        logic [2:0]  exp_codes[$];
        logic [31:0] exp_v[$], exp_al[$], exp_r[$], exp_p[$];
        bit          exp_err = 1'b0, exp_done = 1'b0;
        int          issue_idx = 0, run_len = 0, drop_t = -1, rise_t = -1;
        int          done_cnt = 0, end_t = -1, d, h, a0;
        logic [2:0]  prev_sv = 3'b000;
        logic [31:0] hdr;

        for (int i = 0; i < ncmd; i++) begin
            a0 = (base + CMD_WORDS * i) % MEM_SIZE;
            hdr = $urandom;
            hdr[2:0] = c_code[i];
            hdr[31]  = (i == ncmd - 1);
            mem[a0] = hdr;
            mem[(a0 + 1) % MEM_SIZE] = c_a[i];
            mem[(a0 + 2) % MEM_SIZE] = c_b[i];
            exp_reads.push_back(a0);
            exp_reads.push_back((a0 + 1) % MEM_SIZE);
            exp_reads.push_back((a0 + 2) % MEM_SIZE);
            if (c_code[i] == 3'd0 || c_code[i] > 3'd4) begin
                exp_err = 1'b1;
                break;
            end
            if (c_code[i] == 3'd1) begin
                m_vlr = c_a[i]; m_alpha = c_b[i];
            end else begin
                m_rk = c_a[i]; m_phi = c_b[i];
            end
            exp_codes.push_back(c_code[i]);
            exp_v.push_back(m_vlr); exp_al.push_back(m_alpha);
            exp_r.push_back(m_rk);  exp_p.push_back(m_phi);
            if (i == ncmd - 1) exp_done = 1'b1;
        end

        @(negedge clk);
        base_addr = CMD_AW'(base);
        start     = 1'b1;
        stage_rdy = 1'b1;
        for (int t = 1; t <= BUDGET; t++) begin
            @(negedge clk);
            start     = poke_start && (t == 9);
            base_addr = CMD_AW'($urandom);
            if (t == 1) checkOutput("busy_on", busy, 1);
            if (cmd_bus.cmd_en) obs_reads.push_back(int'(cmd_bus.cmd_addr));
            if (stage_val != 3'b000 && prev_sv == 3'b000) begin
                if (issue_idx < exp_codes.size()) begin
                    checkOutput($sformatf("code%0d", issue_idx), stage_val, exp_codes[issue_idx]);
                    checkOutput($sformatf("vlr%0d", issue_idx), vlr, exp_v[issue_idx]);
                    checkOutput($sformatf("alpha%0d", issue_idx), alpha, exp_al[issue_idx]);
                    checkOutput($sformatf("rk%0d", issue_idx), rk, exp_r[issue_idx]);
                    checkOutput($sformatf("phi%0d", issue_idx), phi, exp_p[issue_idx]);
                end else begin
                    checkOutput("extra_issue", issue_idx, exp_codes.size());
                end
                if (issue_idx == 0) checkOutput("latency", t, 5);
                d = (drop_cfg > 0) ? drop_cfg : $urandom_range(1, 5);
                h = (hold_cfg > 0) ? hold_cfg : $urandom_range(3, 25);
                drop_t = t + d;
                rise_t = drop_t + h;
                issue_idx++;
                run_len = 0;
            end
            if (stage_val != 3'b000) run_len++;
            else if (prev_sv != 3'b000) checkOutput("issue_len", run_len, 2);
            prev_sv = stage_val;
            if (done) begin
                done_cnt++;
                checkOutput("done_time", t, rise_t + 1);
            end
            if (t == drop_t) stage_rdy = 1'b0;
            if (t == rise_t) stage_rdy = 1'b1;
            if (!busy) begin
                end_t = t;
                break;
            end
        end
        start = 1'b0;
        stage_rdy = 1'b1;

        if (end_t < 0) checkOutput("run_timeout", 0, 1);
        checkOutput("n_reads", obs_reads.size(), exp_reads.size());
        for (int i = 0; i < exp_reads.size() && i < obs_reads.size(); i++)
            checkOutput($sformatf("rd_addr%0d", i), obs_reads[i], exp_reads[i]);
        checkOutput("n_issues", issue_idx, exp_codes.size());
        checkOutput("n_done", done_cnt, exp_done ? 1 : 0);
        checkOutput("err", err, exp_err);
        if (exp_err && exp_codes.size() == 0) checkOutput("err_exit_t", end_t, 5);
        checkOutput("fin_vlr", vlr, m_vlr);
        checkOutput("fin_alpha", alpha, m_alpha);
        checkOutput("fin_rk", rk, m_rk);
        checkOutput("fin_phi", phi, m_phi);
        checkOutput("fin_busy", busy, 0);
    endtask

    // Reset lands while the sequencer waits for stage_rdy to return high.
    task automatic applyResetMidWait();
        mem[100] = 32'h0000_0001;
        mem[101] = $urandom;
        mem[102] = $urandom;
        @(negedge clk);
        base_addr = CMD_AW'(100);
        start = 1'b1;
        stage_rdy = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 6) stage_rdy = 1'b0;
        end
        checkOutput("prerst_busy", busy, 1);
        sys_rst = 1'b1;
        @(negedge clk);
        checkAllZero("midrst");
        sys_rst = 1'b0;
        stage_rdy = 1'b1;
        m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
    endtask

    initial begin
        int n, r;
        sys_rst = 1'b1;
        start = 1'b0;
        stage_rdy = 1'b1;
        base_addr = '0;
        m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        checkAllZero("por");
        sys_rst = 1'b0;

        c_code[0] = 3'd4; c_a[0] = 32'd10730636; c_b[0] = 32'hFFFA8509;
        applyStimulus(200, 1, 0, 0, 1'b0);
        checkOutput("assoc_rk_const", rk, 32'h00A3BC8C);
        checkOutput("assoc_phi_const", phi, 32'hFFFA8509);

        c_code[0] = 3'd1; c_a[0] = 32'h0; c_b[0] = 32'hFFFFF753;
        applyStimulus(300, 1, 3, 20, 1'b0);
        checkOutput("prd_vlr_const", vlr, 32'h0);
        checkOutput("prd_alpha_const", alpha, 32'hFFFFF753);
        checkOutput("prd_rk_hold", rk, 32'h00A3BC8C);

        c_code[0] = 3'd1; c_a[0] = $urandom; c_b[0] = $urandom;
        c_code[1] = 3'd4; c_a[1] = $urandom; c_b[1] = $urandom;
        c_code[2] = 3'd3; c_a[2] = $urandom; c_b[2] = $urandom;
        applyStimulus(1020, 3, 0, 0, 1'b1);

        c_code[0] = 3'd7; c_a[0] = $urandom; c_b[0] = $urandom;
        applyStimulus(500, 1, 0, 0, 1'b0);

        applyResetMidWait();
        c_code[0] = 3'd2; c_a[0] = $urandom; c_b[0] = $urandom;
        applyStimulus(40, 1, 0, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                c_code[i] = (r < 18) ? 3'($urandom_range(1, 4))
                          : ((r == 18) ? 3'd0 : 3'($urandom_range(5, 7)));
                c_a[i] = $urandom;
                c_b[i] = $urandom;
            end
            applyStimulus($urandom_range(0, MEM_SIZE - 1), n, 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ekf_stage_seq.md
EKF_STAGE_SEQ -- requirements
Module: ekf_stage_seq

Interface
REQ-001 SHALL have parameter RSA_DW, default 32: operand width, in Q1.12.19 signed format.
REQ-002 SHALL have parameter CMD_AW, default 10: command-memory address width.
REQ-003 SHALL have parameter TMO_W, default 16: watchdog counter width (used only when SEQ_TIMEOUT_EN is defined).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run; sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, CMD_AW bits: address of the first command; latched on start.
REQ-008 SHALL have port cmd_en, output, 1 bit: command-memory read enable.
REQ-009 SHALL have port cmd_addr, output, CMD_AW bits: command-memory read address.
REQ-010 SHALL have port cmd_dout, input, 32 bits: read data, valid exactly 1 cycle after cmd_en.
REQ-011 SHALL have port stage_val, output, 3 bits: stage request to the EKF top; 000 = IDLE, 001 = PRD, 010 = NEW, 011 = UPD, 100 = ASSOC.
REQ-012 SHALL have port vlr, output, RSA_DW bits: PRD velocity operand.
REQ-013 SHALL have port alpha, output, RSA_DW bits: PRD steering operand.
REQ-014 SHALL have port rk, output, RSA_DW bits: observation range operand.
REQ-015 SHALL have port phi, output, RSA_DW bits: observation bearing operand.
REQ-016 SHALL have port stage_rdy, input, 1 bit: level from the EKF top; low while a stage executes, high when idle.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when the run ends normally.
REQ-019 SHALL have port err, output, 1 bit: sticky error flag, cleared by start or sys_rst.

Function
REQ-020 Each command SHALL be 3 consecutive words.
- Header: [2:0] stage code, [31] last flag.
- Word A: vlr (PRD) or rk (NEW/UPD/ASSOC).
- Word B: alpha (PRD) or phi (NEW/UPD/ASSOC).
REQ-021 The state machine SHALL have states IDLE, RD_H, RD_A, RD_B, CAP_B, ISSUE, WAIT_ACK, WAIT_RDY, DONE.
REQ-022 IDLE -> RD_H SHALL occur on start; the pointer p is loaded with base_addr and err is cleared.
REQ-023 The read states SHALL issue and capture words as follows:
- RD_H: assert cmd_en with cmd_addr = p.
- RD_A: assert cmd_en with cmd_addr = p+1; capture the header.
- RD_B: assert cmd_en with cmd_addr = p+2; capture word A.
- CAP_B: capture word B.
cmd_en SHALL be low in every other state.
REQ-024 In CAP_B, a header code of 000 or >100 SHALL set err and go to IDLE with no stage issued.
REQ-025 The operand registers SHALL update only in CAP_B and hold otherwise:
- PRD loads vlr and alpha; rk and phi hold.
- Any other valid code loads rk and phi; vlr and alpha hold.
REQ-026 ISSUE SHALL last exactly 2 cycles, driving stage_val = code; stage_val SHALL be 000 in all other states.
REQ-027 WAIT_ACK SHALL wait for stage_rdy == 0, then move to WAIT_RDY.
REQ-028 WAIT_RDY SHALL wait for stage_rdy == 1, then:
- If last = 1, go to DONE.
- Otherwise set p = p+3 and go to RD_H.
REQ-029 DONE SHALL last 1 cycle with done = 1, then return to IDLE.
REQ-030 p SHALL wrap modulo 2^CMD_AW, so that p+1 and p+2 also wrap.
REQ-031 start SHALL be ignored while busy = 1.
REQ-032 The end-to-end latency SHALL be: start at cycle 0 -> first stage_val asserted at cycle 5.

Reset
REQ-033 sys_rst SHALL force the state machine to IDLE from any state, including mid-ISSUE or mid-wait.
REQ-034 sys_rst SHALL clear stage_val, cmd_en, cmd_addr, vlr, alpha, rk, phi, busy, done, err and p to 0.

Configuration
REQ-035 With SEQ_TIMEOUT_EN defined, a TMO_W-bit counter SHALL run as follows:
- It clears on entry to WAIT_ACK or WAIT_RDY and counts up while in either state.
- On reaching all-ones, err is set and the state goes to IDLE without a done pulse.
REQ-036 Without SEQ_TIMEOUT_EN, the counter SHALL be absent and the wait states SHALL have no timeout.

Structure
REQ-037 Package ekf_pkg SHALL hold:
- the stage codes STAGE_IDLE/PRD/NEW/UPD/ASSOC;
- the state enum;
- the header field positions;
- CMD_WORDS = 3.
REQ-038 The design SHALL be a single module with no sub-module; the command decode is inline.

Verification
REQ-039 Scenario: PRD, last = 1; A = 0, B = 0xFFFFF753 (-2221); stage_rdy drops 3 cycles after ISSUE and rises 20 cycles later.
- Required: stage_val = 001 for exactly 2 cycles; vlr = 0; alpha = 0xFFFFF753; rk and phi unchanged.
- Required: done pulses 1 cycle after stage_rdy rises.
REQ-040 Scenario: ASSOC, rk = 10730636, phi = -359159, last = 1.
- Required: stage_val = 100 for 2 cycles; rk = 0x00A3BC8C; phi = 0xFFFA8509.
REQ-041 Scenario: three chained commands PRD, ASSOC, UPD (last on UPD) at base_addr = 1020.
- Required: reads at 1020, 1021, 1022, then 1023, 0, 1 (wrap), then 2, 3, 4.
- Required: stage codes issued in order 001, 100, 011.
REQ-042 Scenario: header code 111.
- Required: err = 1 and busy = 0 by the cycle after CAP_B; stage_val never nonzero; no done pulse.
REQ-043 Scenario: sys_rst asserted during WAIT_RDY.
- Required: next cycle all outputs are 0 and the state is IDLE; a subsequent start runs normally.
REQ-044 Scenario (SEQ_TIMEOUT_EN defined): stage_rdy held at 1 after ISSUE.
- Required: err = 1 after 2^TMO_W - 1 wait cycles; no done pulse.
